// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared types and constants for the BCD time-of-day clock.
//   rtc_state_t : mode FSM states (RUN, SET_HR, SET_MIN)
//   bcd_digit_t : one 4-bit BCD digit
//   bcd_pair_t  : a tens/ones digit pair (seconds, minutes or hours)
//   SEG_LUT     : active-high {g,f,e,d,c,b,a} patterns for digits 0..9
//   SEG_BLANK   : active-high "all segments off"
//   BCD_BLANK   : out-of-range code the decoder renders as blank
//   bcd_inc59() : increment a 00..59 pair with wrap, no carry out
// ---------------------------------------------------------------------------
package rtc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } rtc_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_pair_t;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Any code above 9 decodes to blank; blinking reuses this instead of a
  // separate blank path through the decoder.
  localparam bcd_digit_t BCD_BLANK = 4'hF;

  function automatic bcd_pair_t bcd_inc59(input bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens == 4'd5) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_hms_display_seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// BCD digit to seven-segment pattern, bit order {g,f,e,d,c,b,a}.
//   digit : BCD code; 10..15 render as blank
//   seg   : pattern, inverted when SEG_ACTIVE_LOW=1
// ---------------------------------------------------------------------------
module seg7_decoder
  import rtc_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  bcd_digit_t  digit,
  output logic [6:0]  seg
);

  logic [6:0] pattern;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pattern = SEG_BLANK;
    if (digit <= 4'd9) pattern = SEG_LUT[digit];
  end

  assign seg = SEG_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/rtc_hms_display.sv
// ---------------------------------------------------------------------------
// rtc_hms_display
// BCD time-of-day clock (HH:MM:SS) with tick prescaler, 12/24 h mode,
// button-driven time set and a midnight pulse, driving six 7-seg digits.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   btn_mode   : debounced pulse, RUN -> SET_HR -> SET_MIN -> RUN
//   btn_inc    : debounced pulse, increments the field being set
//   seg[41:0]  : six digit patterns, [6:0]=sec ones ... [41:35]=hr tens
//   pm         : PM flag (0 when HOUR_12=0)
//   day_pulse  : one cycle on the midnight rollover
//   set_active : high while setting hours or minutes
// Optional build macro RTC_SET_BLINK_EN: blinks the digits being edited
// and lets btn_inc restart the blink phase.
// ---------------------------------------------------------------------------
module rtc_hms_display
  import rtc_pkg::*;
#(
  parameter int TICK_DIV       = 50_000_000,
  parameter bit HOUR_12        = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [41:0] seg,
  output logic        pm,
  output logic        day_pulse,
  output logic        set_active
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam bcd_pair_t       HR_RESET = HOUR_12 ? 8'h12 : 8'h00;

  rtc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  bcd_pair_t        sec_q, min_q, hr_q, hr_nxt;
  logic             pm_q, pm_nxt, hr_day, day_q;
  logic             tick, run_tick, mode_exit, inc_hr, inc_min;
  logic             blink_off, blink_restart;
  bcd_digit_t       disp [6];
  logic [41:0]      seg_d;

  assign tick = (cnt_q == CNT_MAX);

  // Mode FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Mode FSM: next state and per-cycle actions. btn_mode always wins over
  // btn_inc; a RUN tick in the same cycle as btn_mode is still applied.
  always_comb begin
    state_d   = state_q;
    run_tick  = 1'b0;
    mode_exit = 1'b0;
    inc_hr    = 1'b0;
    inc_min   = 1'b0;
    case (state_q)
      RUN: begin
        run_tick = tick;
        if (btn_mode) state_d = SET_HR;
      end
      SET_HR: begin
        if (btn_mode) state_d = SET_MIN;
        else          inc_hr  = btn_inc;
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_d   = RUN;
          mode_exit = 1'b1;
        end else begin
          inc_min = btn_inc;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Next hour value, shared by the RUN carry and the SET_HR increment.
  // hr_day marks the wrap that counts as midnight.
  always_comb begin
    hr_nxt = hr_q;
    pm_nxt = pm_q;
    hr_day = 1'b0;
    if (HOUR_12) begin
      if (hr_q == 8'h12) begin
        hr_nxt = 8'h01;
      end else if (hr_q == 8'h11) begin
        hr_nxt = 8'h12;
        pm_nxt = ~pm_q;
        hr_day = pm_q;
      end else if (hr_q.ones == 4'd9) begin
        hr_nxt = 8'h10;
      end else begin
        hr_nxt.ones = hr_q.ones + 4'd1;
      end
    end else begin
      if (hr_q == 8'h23) begin
        hr_nxt = 8'h00;
        hr_day = 1'b1;
      end else if (hr_q.ones == 4'd9) begin
        hr_nxt.tens = hr_q.tens + 4'd1;
        hr_nxt.ones = 4'd0;
      end else begin
        hr_nxt.ones = hr_q.ones + 4'd1;
      end
    end
  end

`ifdef RTC_SET_BLINK_EN
  assign blink_off     = (state_q != RUN) && (cnt_q >= CNT_W'(TICK_DIV / 2));
  assign blink_restart = inc_hr || inc_min;
`else
  assign blink_off     = 1'b0;
  assign blink_restart = 1'b0;
`endif

  // Time counters and prescaler. Carries ripple combinationally so every
  // digit moves on the same edge.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= HR_RESET;
      pm_q  <= 1'b0;
      day_q <= 1'b0;
    end else begin
      day_q <= 1'b0;
      if (tick || mode_exit || blink_restart) cnt_q <= '0;
      else                                    cnt_q <= cnt_q + 1'b1;

      if (run_tick) begin
        sec_q <= bcd_inc59(sec_q);
        if (sec_q == 8'h59) begin
          min_q <= bcd_inc59(min_q);
          if (min_q == 8'h59) begin
            hr_q  <= hr_nxt;
            pm_q  <= pm_nxt;
            day_q <= hr_day;
          end
        end
      end
      if (inc_min) min_q <= bcd_inc59(min_q);
      if (inc_hr) begin
        hr_q <= hr_nxt;
        pm_q <= pm_nxt;
      end
      if (mode_exit) sec_q <= '0;
    end
  end

  assign day_pulse = day_q;

  always_comb begin
    disp[0] = sec_q.ones;
    disp[1] = sec_q.tens;
    disp[2] = min_q.ones;
    disp[3] = min_q.tens;
    disp[4] = hr_q.ones;
    disp[5] = hr_q.tens;
    if (blink_off && state_q == SET_MIN) begin
      disp[2] = BCD_BLANK;
      disp[3] = BCD_BLANK;
    end
    if (blink_off && state_q == SET_HR) begin
      disp[4] = BCD_BLANK;
      disp[5] = BCD_BLANK;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_dec
    seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
      .digit (disp[i]),
      .seg   (seg_d[i*7 +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm         <= 1'b0;
      set_active <= 1'b0;
    end else begin
      pm         <= HOUR_12 ? pm_q : 1'b0;
      set_active <= (state_q != RUN);
    end
  end

  // NOTE: seg is reloaded from the counters every cycle, so it needs no
  // reset; it shows the reset time one edge after rst is sampled.
  always_ff @(posedge clk) begin
    seg <= seg_d;
  end

endmodule

// File: tb/tb_rtc_hms_display.sv
module tb_rtc_hms_display;

  localparam logic [6:0] LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [41:0] seg24, seg12;
  logic        pm24, pm12, dp24, dp12, sa24, sa12;

  int n_tests = 0;
  int n_fail  = 0;
  int c24, c12;

  rtc_hms_display #(.TICK_DIV(4), .HOUR_12(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_dut24 (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .seg(seg24), .pm(pm24), .day_pulse(dp24), .set_active(sa24)
  );

  rtc_hms_display #(.TICK_DIV(4), .HOUR_12(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut12 (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .seg(seg12), .pm(pm12), .day_pulse(dp12), .set_active(sa12)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] exp_seg(input int hh, input int mm, input int ss);
    logic [41:0] r;
    int d [6];
    d[0] = ss % 10; d[1] = ss / 10;
    d[2] = mm % 10; d[3] = mm / 10;
    d[4] = hh % 10; d[5] = hh / 10;
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = ~LUT[d[i]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
    end
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (dp24) c24++;
      if (dp12) c12++;
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    rst = 1'b0;
    check("reset_seg24", seg24, {6{7'h40}});
    check("reset_seg12", seg12, exp_seg(12, 0, 0));
    check("reset_pm12", pm12, 0);
    check("reset_pm24", pm24, 0);
    check("reset_dp24", dp24, 0);
    check("reset_sa24", sa24, 0);

    // Seconds -> minutes carry; first tick lands 4 edges after reset release
    repeat (237) step();
    check("carry_59_24", seg24, exp_seg(0, 0, 59));
    check("carry_59_12", seg12, exp_seg(12, 0, 59));
    repeat (3) step();
    check("pre_carry", seg24, exp_seg(0, 0, 59));
    step();
    check("carry_min24", seg24, exp_seg(0, 1, 0));
    check("carry_min12", seg12, exp_seg(12, 1, 0));
    check("carry_dp", dp24, 0);

    // Set-mode edit, entered with seconds = 02
    do_reset();
    repeat (8) step();
    pulse_mode();
    check("sa_latency", sa24, 0);
    step();
    check("sa_set_hr", sa24, 1);
    check("sa_set_hr12", sa12, 1);
    repeat (20) step();
    check("hold_sec_hr", seg24, exp_seg(0, 0, 2));
    check("hold_sec_hr12", seg12, exp_seg(12, 0, 2));
    pulse_inc(25);
    step();
    check("inc_hr24", seg24, exp_seg(1, 0, 2));
    check("inc_hr12", seg12, exp_seg(1, 0, 2));
    check("inc_hr12_pm", pm12, 0);
    // Mode and increment together: mode wins
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step();
    check("simul_hr", seg24, exp_seg(1, 0, 2));
    check("simul_sa", sa24, 1);
    pulse_inc(61);
    step();
    check("inc_min", seg24, exp_seg(1, 1, 2));
    repeat (20) step();
    check("hold_sec_min", seg24, exp_seg(1, 1, 2));
    pulse_mode();
    step();
    check("sec_clear", seg24, exp_seg(1, 1, 0));
    check("sa_run", sa24, 0);
    repeat (3) step();
    check("pre_first_tick", seg24, exp_seg(1, 1, 0));
    step();
    check("prescaler_clear", seg24, exp_seg(1, 1, 1));

    // Midnight: 24 h 23:59 and 12 h 11:59 PM from the same button sequence
    do_reset();
    repeat (40) step();
    pulse_mode();
    pulse_inc(23);
    pulse_mode();
    pulse_inc(59);
    pulse_mode();
    step();
    check("set_2359", seg24, exp_seg(23, 59, 0));
    check("set_1159", seg12, exp_seg(11, 59, 0));
    check("set_1159_pm", pm12, 1);
    c24 = 0;
    c12 = 0;
    run_count(236);
    check("at_235959", seg24, exp_seg(23, 59, 59));
    check("at_115959", seg12, exp_seg(11, 59, 59));
    run_count(2);
    run_count(1);
    check("dp24_wrap", dp24, 1);
    check("dp12_wrap", dp12, 1);
    run_count(1);
    check("midnight24", seg24, exp_seg(0, 0, 0));
    check("midnight12", seg12, exp_seg(12, 0, 0));
    check("midnight12_pm", pm12, 0);
    run_count(20);
    check("dp24_count", c24, 1);
    check("dp12_count", c12, 1);

    // 12 h: 12:59:59 -> 01:00:00, no day pulse
    do_reset();
    pulse_mode();
    pulse_mode();
    pulse_inc(59);
    pulse_mode();
    c24 = 0;
    c12 = 0;
    run_count(237);
    check("at_125959", seg12, exp_seg(12, 59, 59));
    check("at_005959", seg24, exp_seg(0, 59, 59));
    run_count(4);
    check("one_oclock12", seg12, exp_seg(1, 0, 0));
    check("one_oclock12_pm", pm12, 0);
    check("one_oclock24", seg24, exp_seg(1, 0, 0));
    check("no_dp12", c12, 0);
    check("no_dp24", c24, 0);

    // Reset in SET_MIN discards the edit
    pulse_mode();
    pulse_mode();
    pulse_inc(5);
    do_reset();
    check("rst_set_seg24", seg24, exp_seg(0, 0, 0));
    check("rst_set_seg12", seg12, exp_seg(12, 0, 0));
    check("rst_set_sa", sa24, 0);
    repeat (5) step();
    check("rst_set_run", seg24, exp_seg(0, 0, 1));
    check("rst_set_sa_run", sa24, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
